dual_tick_sched: RTL and testbench
==================================

# dual_tick_sched

Single-clock scheduler that drives two independent tick streams for the dual-counter test harness, standing in for two free-running user clocks.
- Each stream fires a one-cycle strobe every programmable number of cycles and counts the strobes it has issued.
- A config handshake and start/stop controls sequence runs; a burst mode ends a run after N stream-1 ticks.
- Sits between the cocotb-driven control inputs and the ticked logic.

## Interface
- CNT_W, 32, width of tick counters and burst length
- DIV_W, 8, width of divider and skew fields
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_valid  input  1  config offer
- cfg_ready  output  1  config accepted when high with cfg_valid
- cfg_div1  input  DIV_W  stream-1 period in cycles; 0 treated as 1
- cfg_div2  input  DIV_W  stream-2 period in cycles; 0 treated as 1
- cfg_burst  input  CNT_W  stream-1 tick limit; 0 = free-run
- start  input  1  begin run (sampled in IDLE only)
- stop  input  1  abort run (sampled in RUN only)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, run ended
- tick1, tick2  output  1  registered one-cycle strobes
- count1, count2  output  CNT_W  ticks issued this run, wrap modulo 2^CNT_W

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, rst_n low): state IDLE; tick1/tick2/done/busy = 0; count1/count2 = 0; latched div1 = div2 = 1; burst = 0. cfg_ready returns to 1 immediately.
- cfg_ready = (state == IDLE).
- Handshake cfg_valid & cfg_ready latches div1, div2, burst (and skew2 when enabled).
- IDLE -> RUN on start:
  - count1/count2 cleared; phase counters cleared.
  - If cfg_valid and start are high in the same cycle, the run uses the newly latched config.
- RUN behaviour:
  - The k-th tick1 (k >= 1) is high for the cycle beginning at edge E0 + k*div1, where E0 is the edge that sampled start; tick2 likewise with div2.
  - With a divider of 1, the tick is high every cycle from E0+1.
  - countN increments at the same edge tickN rises.
- RUN -> DONE:
  - When burst != 0, at the edge issuing the burst-th tick1. That tick is issued.
  - On stop, at the next edge. No ticks are issued at that edge.
  - Stop coincident with the final burst tick: the tick is issued and the state goes to DONE (single done).
- DONE: done = 1 and ticks are 0 for one cycle, then IDLE.
- count1/count2 hold their final values until the next start.
- Ignored inputs: start while busy; stop outside RUN; cfg_valid outside IDLE (cfg_ready low, no latch).
- A tick2 due at the burst-ending edge is issued.

## Timing
- Start-to-busy: 1 cycle (busy high from E0).
- First tick latency: div cycles after E0.
- Stop-to-done: done high in the cycle after the stop edge; busy low 2 cycles after stop is sampled.
- All outputs are registered except cfg_ready and busy, which are decoded from the state register.
- Divider phase wraps at div-1 → 0 with no idle cycle.

## Configuration
- DUAL_TICK_SKEW_EN defined:
  - Adds input cfg_skew2 [DIV_W], latched with the config.
  - The k-th tick2 is at E0 + skew2 + k*div2.
  - A skew2 >= div2 is treated as 0.
- DUAL_TICK_SKEW_EN undefined: the port is absent and tick2 timing is as in Operation.

## Test plan
- Reset mid-run (div1=3, after 5 ticks, pull rst_n low async):
  - All outputs 0 without a clock edge.
  - After release, a start with no config runs div=1/1 free-run.
- cfg div1=2, div2=3, burst=0; start; 12 cycles; stop:
  - tick1 at E0+2,4,…,12 and tick2 at E0+3,6,9,12.
  - count1=6, count2=4, done one cycle later.
- cfg div1=1, burst=4; start:
  - tick1 high E0+1..E0+4, count1=4.
  - done at E0+5, busy low at E0+6.
- cfg_valid with div1=5 asserted together with start in IDLE:
  - First tick1 at E0+5.
  - A second cfg_valid during RUN sees cfg_ready=0 and the config is unchanged.
- burst=2, div1=4, stop asserted so it is sampled at E0+8:
  - tick1 at E0+8 is issued, count1=2, exactly one done pulse.
- With DUAL_TICK_SKEW_EN, div2=4, skew2=1: tick2 at E0+5,9,13. With skew2=6: tick2 at E0+4,8,12.

Source files
------------

// File: rtl/dual_tick_sched.sv
// dual_tick_sched: single-clock scheduler producing two independent programmable tick
// streams with per-run strobe counters. It has a config handshake, start/stop control and
// an optional stream-1 burst limit.
// Optional feature: define DUAL_TICK_SKEW_EN to add cfg_skew2, which delays stream 2.
module dual_tick_sched #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div1,
    input  logic [DIV_W-1:0] cfg_div2,
    input  logic [CNT_W-1:0] cfg_burst,
`ifdef DUAL_TICK_SKEW_EN
    input  logic [DIV_W-1:0] cfg_skew2,
`endif
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             tick1,
    output logic             tick2,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div1_q, div2_q;
    logic [DIV_W-1:0] phase1_q, phase2_q;
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] count1_q, count2_q;
    logic             tick1_q, tick2_q, done_q;

    logic             cfg_fire, start_fire, in_run, skew_wait;
    logic             fire1, fire2, burst_end, issue;
    logic [DIV_W-1:0] new_div1, new_div2;

    assign cfg_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign start_fire = start & (state_q == StIdle);
    assign in_run     = (state_q == StRun);

    // A zero divider behaves like a divider of one.
    assign new_div1 = (cfg_div1 == '0) ? DIV_W'(1) : cfg_div1;
    assign new_div2 = (cfg_div2 == '0) ? DIV_W'(1) : cfg_div2;

    assign fire1     = in_run && (phase1_q == div1_q - DIV_W'(1));
    assign fire2     = in_run && !skew_wait && (phase2_q == div2_q - DIV_W'(1));
    assign burst_end = fire1 && (burst_q != '0) && (count1_q + CNT_W'(1) == burst_q);
    // The final burst tick is issued even when stop arrives on the same edge.
    assign issue     = in_run && (burst_end || !stop);

`ifdef DUAL_TICK_SKEW_EN
    logic [DIV_W-1:0] skew2_q, skew_cnt_q, new_skew2;

    // A skew of a full period or more collapses to no skew.
    assign new_skew2 = (cfg_skew2 >= new_div2) ? '0 : cfg_skew2;
    assign skew_wait = (skew_cnt_q != '0);

    // Stream-2 skew latch and pre-roll countdown that holds phase2 at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew2_q    <= '0;
            skew_cnt_q <= '0;
        end else begin
            if (cfg_fire) begin
                skew2_q <= new_skew2;
            end
            if (start_fire) begin
                skew_cnt_q <= cfg_fire ? new_skew2 : skew2_q;
            end else if (in_run && skew_wait) begin
                skew_cnt_q <= skew_cnt_q - DIV_W'(1);
            end
        end
    end
`else
    assign skew_wait = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. DONE spends one cycle arming done and one cycle showing it, so
    // busy drops two cycles after the ending edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (burst_end || stop) state_d = StDone;
            StDone: if (done_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Config latch, phase counters, tick strobes, tick counters and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div1_q   <= DIV_W'(1);
            div2_q   <= DIV_W'(1);
            burst_q  <= '0;
            phase1_q <= '0;
            phase2_q <= '0;
            count1_q <= '0;
            count2_q <= '0;
            tick1_q  <= 1'b0;
            tick2_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick1_q <= 1'b0;
            tick2_q <= 1'b0;
            done_q  <= (state_q == StDone) && !done_q;
            if (cfg_fire) begin
                div1_q  <= new_div1;
                div2_q  <= new_div2;
                burst_q <= cfg_burst;
            end
            if (start_fire) begin
                phase1_q <= '0;
                phase2_q <= '0;
                count1_q <= '0;
                count2_q <= '0;
            end else if (issue) begin
                tick1_q <= fire1;
                tick2_q <= fire2;
                if (fire1) begin
                    phase1_q <= '0;
                    count1_q <= count1_q + CNT_W'(1);
                end else begin
                    phase1_q <= phase1_q + DIV_W'(1);
                end
                if (fire2) begin
                    phase2_q <= '0;
                    count2_q <= count2_q + CNT_W'(1);
                end else if (!skew_wait) begin
                    phase2_q <= phase2_q + DIV_W'(1);
                end
            end
        end
    end

    assign tick1  = tick1_q;
    assign tick2  = tick2_q;
    assign done   = done_q;
    assign count1 = count1_q;
    assign count2 = count2_q;

endmodule

// File: tb/tb_dual_tick_sched.sv
// tb_dual_tick_sched: scoreboard bench for dual_tick_sched. Each run's expected tick/done
// events are computed from period arithmetic and queued; a monitor pops one per observed
// event. Build with DUAL_TICK_SKEW_EN to also exercise the stream-2 skew.
module tb_dual_tick_sched;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div1 = '0;
    logic [DIV_W-1:0] cfg_div2 = '0;
    logic [CNT_W-1:0] cfg_burst = '0;
`ifdef DUAL_TICK_SKEW_EN
    logic [DIV_W-1:0] cfg_skew2 = '0;
`endif
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy, done, tick1, tick2;
    logic [CNT_W-1:0] count1, count2;

    dual_tick_sched #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div1  (cfg_div1),
        .cfg_div2  (cfg_div2),
        .cfg_burst (cfg_burst),
`ifdef DUAL_TICK_SKEW_EN
        .cfg_skew2 (cfg_skew2),
`endif
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .tick1     (tick1),
        .tick2     (tick2),
        .count1    (count1),
        .count2    (count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit t1;
        bit t2;
        bit dn;
        int c1;
        int c2;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    // Model of the latched configuration (effective values).
    int  lat_d1 = 1, lat_d2 = 1, lat_sk = 0, lat_bu = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Queue the events of one run; returns the offset of the edge that ends the run.
    function automatic int push_model(input int e0, input int d1, input int d2, input int sk,
                                      input int bu, input int stop_at);
        int   fin, last, c1, c2;
        bit   t1, t2;
        ev_t  ev;
        c1 = 0;
        c2 = 0;
        if (bu != 0 && (stop_at == 0 || bu * d1 <= stop_at)) begin
            fin  = bu * d1;
            last = fin;
        end else begin
            fin  = stop_at;
            last = fin - 1;
        end
        for (int m = 1; m <= last; m++) begin
            t1 = (m % d1) == 0;
            t2 = (m > sk) && (((m - sk) % d2) == 0);
            if (t1 || t2) begin
                c1 += int'(t1);
                c2 += int'(t2);
                ev.cyc = e0 + m; ev.t1 = t1; ev.t2 = t2; ev.dn = 1'b0; ev.c1 = c1; ev.c2 = c2;
                exp_q.push_back(ev);
            end
        end
        ev.cyc = e0 + fin + 1; ev.t1 = 1'b0; ev.t2 = 1'b0; ev.dn = 1'b1; ev.c1 = c1; ev.c2 = c2;
        exp_q.push_back(ev);
        return fin;
    endfunction

    // Monitor: every cycle showing a tick or done consumes one expected event.
    always @(negedge clk) begin
        if (rst_n && (tick1 || tick2 || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event: unexpected t1=%b t2=%b done=%b at cycle %0d, required none",
                         tick1, tick2, done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || tick1 !== mon_e.t1 || tick2 !== mon_e.t2 ||
                    done !== mon_e.dn || count1 !== CNT_W'(mon_e.c1) ||
                    count2 !== CNT_W'(mon_e.c2)) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d t1=%b t2=%b done=%b c1=%0d c2=%0d, required cyc=%0d t1=%b t2=%b done=%b c1=%0d c2=%0d",
                             cyc, tick1, tick2, done, count1, count2,
                             mon_e.cyc, mon_e.t1, mon_e.t2, mon_e.dn, mon_e.c1, mon_e.c2);
                end
            end
        end
    end

    task automatic latch_model(input int d1, input int d2, input int sk, input int bu);
        lat_d1 = (d1 == 0) ? 1 : d1;
        lat_d2 = (d2 == 0) ? 1 : d2;
        lat_bu = bu;
`ifdef DUAL_TICK_SKEW_EN
        lat_sk = (sk >= lat_d2) ? 0 : sk;
`else
        lat_sk = 0;
`endif
    endtask

    task automatic drive_cfg(input int d1, input int d2, input int sk, input int bu);
        cfg_div1  = DIV_W'(d1);
        cfg_div2  = DIV_W'(d2);
        cfg_burst = CNT_W'(bu);
`ifdef DUAL_TICK_SKEW_EN
        cfg_skew2 = DIV_W'(sk);
`endif
        cfg_valid = 1'b1;
    endtask

    // One complete run; called at #1 after a rising edge with the DUT idle.
    task automatic do_run(input bit do_cfg, input bit same_cycle, input int d1, input int d2,
                          input int sk, input int bu, input int stop_at, input bit poke);
        int e0, fin;
        if (do_cfg) begin
            drive_cfg(d1, d2, sk, bu);
            if (!same_cycle) begin
                chk("cfg_ready_idle", cfg_ready, 1);
                @(posedge clk); #1;
                cfg_valid = 1'b0;
            end
            latch_model(d1, d2, sk, bu);
        end
        start = 1'b1;
        e0 = cyc + 1;
        fin = push_model(e0, lat_d1, lat_d2, lat_sk, lat_bu, stop_at);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        chk("busy_at_e0", busy, 1);
        chk("cfg_ready_at_e0", cfg_ready, 0);
        chk("count1_cleared", count1, 0);
        chk("count2_cleared", count2, 0);
        while (cyc < e0 + fin + 2) begin
            stop = (stop_at != 0) && (cyc == e0 + stop_at - 1);
            if (poke && cyc == e0 + 1) begin
                chk("cfg_ready_in_run", cfg_ready, 0);
                drive_cfg(2, 2, 0, 1);
            end else begin
                cfg_valid = 1'b0;
            end
            if (cyc == e0 + fin + 1) chk("busy_during_done", busy, 1);
            @(posedge clk); #1;
        end
        stop = 1'b0;
        cfg_valid = 1'b0;
        chk("busy_low_after_done", busy, 0);
        chk("cfg_ready_after_done", cfg_ready, 1);
        chk("events_pending", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, required finish before 400000");
        $fatal(1);
    end

    initial begin
        int e0, d1, d2, sk, bu, st;
        bit dc, sc, pk;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        chk("reset_count1", count1, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a div1=3 run, while the fifth tick1 is high.
        drive_cfg(3, 3, 0, 0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        latch_model(3, 3, 0, 0);
        start = 1'b1;
        e0 = cyc + 1;
        void'(push_model(e0, 3, 3, 0, 0, 60));
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < e0 + 15) begin
            @(posedge clk); #1;
        end
        chk("tick1_before_reset", tick1, 1);
        chk("count1_before_reset", count1, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tick1", tick1, 0);
        chk("async_tick2", tick2, 0);
        chk("async_done", done, 0);
        chk("async_busy", busy, 0);
        chk("async_count1", count1, 0);
        chk("async_count2", count2, 0);
        chk("async_cfg_ready", cfg_ready, 1);
        exp_q.delete();
        latch_model(1, 1, 0, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Defaults after reset: div 1/1 free-run.
        do_run(1'b0, 1'b0, 0, 0, 0, 0, 5, 1'b0);
        // div1=2, div2=3, stop sampled after 12 cycles.
        do_run(1'b1, 1'b0, 2, 3, 0, 0, 13, 1'b0);
        // Burst of 4 at div1=1.
        do_run(1'b1, 1'b0, 1, 2, 0, 4, 0, 1'b0);
        // Config together with start, then an ignored config offer during the run.
        do_run(1'b1, 1'b1, 5, 3, 0, 0, 17, 1'b1);
        do_run(1'b0, 1'b0, 0, 0, 0, 0, 11, 1'b0);
        // Stop coincident with the final burst tick.
        do_run(1'b1, 1'b0, 4, 3, 0, 2, 8, 1'b0);
        // Zero dividers act as one.
        do_run(1'b1, 1'b0, 0, 0, 0, 3, 0, 1'b0);
`ifdef DUAL_TICK_SKEW_EN
        do_run(1'b1, 1'b0, 2, 4, 1, 0, 14, 1'b0);
        do_run(1'b1, 1'b0, 2, 4, 6, 0, 13, 1'b0);
`endif

        for (int r = 0; r < 40; r++) begin
            d1 = int'($urandom_range(0, 6));
            d2 = int'($urandom_range(0, 6));
            sk = int'($urandom_range(0, 7));
            bu = int'($urandom_range(0, 5));
            st = (bu != 0 && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 40));
            dc = ($urandom_range(0, 3) != 0);
            sc = ($urandom_range(0, 1) == 1);
            pk = ($urandom_range(0, 3) == 0);
            do_run(dc, sc, d1, d2, sk, bu, st, pk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
